// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the architectural PC and keeps one instruction-memory read in flight.
// Define FETCH_MISALIGN_TRAP_EN to turn a misaligned PC into a trapped NOP instead of a memory read.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready,
  output logic        read_done,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        fetch_misaligned,
`endif
  output logic [31:0] pc
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        discard_q, discard_d;
  logic        read_done_q, read_done_d;
  logic        misaligned_s;
  logic        gnt_s;
  logic        fire_s;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misaligned_q, misaligned_d;
  assign misaligned_s     = (pc_q[1:0] != 2'b00);
  assign fetch_misaligned = misaligned_q;
`else
  assign misaligned_s = 1'b0;
`endif

  // A grant only counts while a request is actually being driven.
  assign imem_req  = (state_q == ST_REQ) && !misaligned_s;
  assign imem_addr = pc_q;
  assign gnt_s     = imem_gnt && imem_req;
  assign if_valid  = (state_q == ST_VALID);
  assign fire_s    = if_valid && id_ready && !flush;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign read_done = read_done_q;
  assign pc        = pc_q;

  // Next-state logic for the fetch FSM; flush overrides everything else in every state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    discard_d   = discard_q;
    read_done_d = 1'b0;
    case (state_q)
      ST_REQ: begin
        if (flush) begin
          pc_d = next_pc;
          if (gnt_s) begin
            // The old request is already accepted; its response must be thrown away.
            state_d   = ST_WAIT;
            discard_d = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end else if (misaligned_s) begin
          state_d    = ST_VALID;
          if_instr_d = NOP_INSTR;
          if_pc_d    = pc_q;
        end else if (gnt_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          pc_d = next_pc;
          if (imem_rvalid) begin
            state_d   = ST_REQ;
            discard_d = 1'b0;
          end else begin
            state_d   = ST_WAIT;
            discard_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (discard_q) begin
            state_d   = ST_REQ;
            discard_d = 1'b0;
          end else begin
            state_d     = ST_VALID;
            if_instr_d  = imem_rdata;
            if_pc_d     = pc_q;
            read_done_d = 1'b1;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_VALID: begin
        if (flush) begin
          pc_d    = next_pc;
          state_d = ST_REQ;
        end else if (fire_s) begin
          pc_d    = next_pc;
          state_d = ST_REQ;
        end else begin
          state_d = ST_VALID;
        end
      end
      default: begin
        state_d   = ST_REQ;
        discard_d = 1'b0;
      end
    endcase
  end

  // Fetch state, PC and presented-instruction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_VECTOR;
      if_pc_q     <= RESET_VECTOR;
      if_instr_q  <= NOP_INSTR;
      discard_q   <= 1'b0;
      read_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
      discard_q   <= discard_d;
      read_done_q <= read_done_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Trap flag rises when a misaligned PC is turned into a NOP and clears when it leaves.
  always_comb begin
    misaligned_d = misaligned_q;
    if (flush || fire_s) begin
      misaligned_d = 1'b0;
    end else if ((state_q == ST_REQ) && misaligned_s) begin
      misaligned_d = 1'b1;
    end else begin
      misaligned_d = misaligned_q;
    end
  end

  // Trap flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end
`endif

endmodule
